// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and owner ids.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic arb_state_e serve_state(input logic own);
        return (own == OWN_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction timeout counter: cleared on grant, advanced on every serve cycle
// without an acknowledge; expire flags the cycle whose edge reaches TO_CYCLES.
module mem_arb_timer #(
    parameter int TO_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TO_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle count for the transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus.
// Define MEM_ARB_RR_EN to break ties toward the port not granted last;
// otherwise the data port always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TO_CYCLES = 64,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy,
    output logic          err
);

    arb_state_e state_r;
    logic       i_elig_s;
    logic       d_elig_s;
    logic       serving_s;
    logic       grant_s;
    logic       grant_own_s;
    logic       tmr_en_s;
    logic       expire_s;
`ifdef MEM_ARB_RR_EN
    logic       last_own_r;
`endif

    // Eligibility and grant choice; a port is ignored in its own ready cycle
    always_comb begin
        i_elig_s  = i_req && !i_ready;
        d_elig_s  = d_req && !d_ready;
        serving_s = (state_r != IDLE);
        grant_s   = !serving_s && (i_elig_s || d_elig_s);
        tmr_en_s  = serving_s && !m_ack;
`ifdef MEM_ARB_RR_EN
        if (i_elig_s && d_elig_s) begin
            grant_own_s = (last_own_r == OWN_I) ? OWN_D : OWN_I;
        end else if (d_elig_s) begin
            grant_own_s = OWN_D;
        end else begin
            grant_own_s = OWN_I;
        end
`else
        if (d_elig_s) begin
            grant_own_s = OWN_D;
        end else begin
            grant_own_s = OWN_I;
        end
`endif
    end

    mem_arb_timer #(
        .TO_CYCLES(TO_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (grant_s),
        .en     (tmr_en_s),
        .expire (expire_s)
    );

    // Arbiter FSM, bus drive registers and per-port completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_own_r <= OWN_I;
`endif
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            err     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r <= serve_state(grant_own_s);
                        busy    <= 1'b1;
                        m_req   <= 1'b1;
                        if (grant_own_s == OWN_D) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_we    <= d_we;
                        end else begin
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                            m_we    <= 1'b0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_own_r <= grant_own_s;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    // An acknowledge on the expiry edge still completes normally
                    if (m_ack || expire_s) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        m_req   <= 1'b0;
                        err     <= expire_s;
                        if (state_r == SERVE_I) begin
                            i_ready <= 1'b1;
                            i_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            d_ready <= 1'b1;
                            if (!m_ack) begin
                                d_rdata <= '0;
                            end else if (!m_we) begin
                                d_rdata <= m_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    m_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TO_CYCLES, default 64; maximum cycles waited for m_ack before a transaction is aborted.
REQ-002 Parameter: AW, default 32; address width.
REQ-003 Parameter: DW, default 32; data width.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1  instruction-fetch request; held until i_ready.
REQ-007 i_addr  in  AW  fetch address.
REQ-008 i_rdata  out  DW  fetched instruction.
REQ-009 i_ready  out  1  one-cycle completion pulse for fetch.
REQ-010 d_req  in  1  data request; held until d_ready.
REQ-011 d_we  in  1  data write enable (1 = store, 0 = load).
REQ-012 d_addr  in  AW  data address.
REQ-013 d_wdata  in  DW  store data.
REQ-014 d_rdata  out  DW  load data.
REQ-015 d_ready  out  1  one-cycle completion pulse for data.
REQ-016 m_req, m_we  out  1  shared memory request and write enable.
REQ-017 m_addr  out  AW, m_wdata  out  DW  shared memory address and write data.
REQ-018 m_rdata  in  DW, m_ack  in  1  memory read data, and one-cycle completion.
REQ-019 busy  out  1  high in any non-IDLE state.
REQ-020 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE -> SERVE_x when an eligible request is present.
- SERVE_x -> IDLE on m_ack or timeout.
REQ-022 On the IDLE grant edge: owner's addr, wdata and we latch into m_addr, m_wdata and m_we; m_req goes to 1.
- m_req rises one cycle after the request is first seen.
- m_req, m_addr, m_wdata and m_we stay stable until the transaction ends.
REQ-023 m_ack sampled high in SERVE_x:
- on that edge, m_req drops to 0 and the state returns to IDLE;
- the owner's ready pulses high for exactly the next cycle.
REQ-024 Read data:
- on a read, the owner's rdata register loads m_rdata on the ack edge;
- a write leaves d_rdata unchanged;
- rdata holds until the next read completion for that port.
REQ-025 Minimum transaction latency: request seen at cycle N, m_ack at N+1, ready at N+2.
REQ-026 In the cycle a port's ready is high, that port's req is ignored (not eligible), preventing double service.
REQ-027 Simultaneous eligible i_req and d_req in IDLE: d is granted (fixed priority, unless REQ-033 applies).
REQ-028 Timeout counter:
- clears on grant and increments each SERVE cycle without m_ack;
- on reaching TO_CYCLES: m_req drops, owner ready pulses with rdata = 0, err pulses, state returns to IDLE.
REQ-029 m_ack while in IDLE is ignored; no ready or err is generated.

Reset
REQ-030 Reset sampled high, on that edge:
- state = IDLE;
- m_req = m_we = 0, m_addr = 0, m_wdata = 0;
- i_rdata = d_rdata = 0, i_ready = d_ready = 0;
- busy = 0, err = 0, timeout counter = 0, last-grant = I.
REQ-031 Reset mid-transaction aborts the transaction with no ready or err pulse; m_req is 0 from the following cycle.
REQ-032 Reset has priority over m_ack and requests in the same cycle.

Configuration
REQ-033 Macro MEM_ARB_RR_EN:
- defined: ties go to the port not most recently granted, tracked by a last-grant register (reset value I, so the first tie goes to D);
- undefined: fixed D-over-I priority and no last-grant register.

Structure
REQ-034 Package mem_arb_pkg holds the state enum (IDLE/SERVE_I/SERVE_D) and the owner encoding constants OWN_I = 0, OWN_D = 1.
REQ-035 One sub-module, mem_arb_timer: the timeout counter, with clear/enable inputs and an expire output.

Verification
REQ-036 Lone i_req, addr 0x00400000, m_ack 2 cycles after m_req with m_rdata 0x2008000A -> i_ready pulses once, i_rdata = 0x2008000A, d_ready stays 0.
REQ-037 Store: d_req, d_we = 1, d_addr 0x10010004, d_wdata 0xDEADBEEF -> m_we = 1 with matching addr/data; after ack, d_ready pulses and d_rdata is unchanged.
REQ-038 i_req and d_req both high in the same cycle, repeatedly:
- without MEM_ARB_RR_EN -> D served every time first;
- with MEM_ARB_RR_EN -> grant order D, I, D, I.
REQ-039 TO_CYCLES = 4 and m_ack never asserted -> after 4 SERVE cycles: err pulses, owner ready pulses, rdata = 0, m_req = 0, state IDLE.
REQ-040 Reset asserted 1 cycle after m_req rises -> m_req = 0 next cycle, no ready, all outputs at reset values; a new i_req afterwards completes normally.
